// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the quad seven-segment display interface.
// Segment patterns are {a,b,c,d,e,f,g}, active-low (0 = lit).
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Alternate glyphs some drivers use (7 with segment f, 9 without segment d).
    localparam logic [6:0] SEG_7_ALT = 7'b0001101;
    localparam logic [6:0] SEG_9_ALT = 7'b0001100;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
// o_hit is low for any pattern outside the table; o_nibble is then 0.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b1;
        o_nibble = 4'h0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_7_ALT: o_nibble = 4'h7;
            SEG_9_ALT: o_nibble = 4'h9;
            default:   o_hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed 4-digit seven-segment bus and holds the decoded digits.
// Define SEVSEG_ERR_CNT_EN to add the err_cnt output and err_clr input.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 262144
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       ca,
    input  logic       cb,
    input  logic       cc,
    input  logic       cd,
    input  logic       ce,
    input  logic       cf,
    input  logic       cg,
    input  logic       dp,
    output logic [3:0] val3,
    output logic [3:0] val2,
    output logic [3:0] val1,
    output logic [3:0] val0,
    output logic [3:0] valid,
    output logic       seg_err,
    output logic       frame_done,
    output logic       blank,
`ifdef SEVSEG_ERR_CNT_EN
    input  logic       err_clr,
    output logic [7:0] err_cnt,
`endif
    output logic [1:0] o_dbg_state,
    output logic       o_dbg_dp
);

    localparam int              NPIN     = 12;
    localparam logic [7:0]      CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam int              TO_W     = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(FRAME_TIMEOUT - 1);

    logic [NPIN-1:0] r_sync [SYNC_STAGES];
    cap_state_t      r_state;
    logic [7:0]      r_cnt;
    logic [8:0]      r_last;
    logic [3:0]      r_val [4];
    logic [3:0]      r_valid;
    logic [3:0]      r_mask;
    logic            r_blank;
    logic            r_seg_err;
    logic            r_frame;
    logic [TO_W-1:0] r_to;

    logic [NPIN-1:0] w_pins;
    logic [3:0]      w_an_low;
    logic [6:0]      w_seg;
    logic            w_digit_ok;
    digit_idx_t      w_idx;
    logic [8:0]      w_tuple;
    logic            w_same;
    logic            w_hit;
    logic [3:0]      w_nibble;
    logic            w_capture;
    logic            w_hit_cap;
    logic            w_miss_cap;
    logic [3:0]      w_mask_set;
    logic            w_frame;
    logic            w_to_sat;

    // Idle pins are all high, so the synchronizer resets to "no digit".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
        end else begin
            r_sync[0] <= {an3, an2, an1, an0, ca, cb, cc, cd, ce, cf, cg, dp};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_pins     = r_sync[SYNC_STAGES-1];
    assign w_an_low   = ~w_pins[11:8];
    assign w_seg      = w_pins[7:1];
    assign w_digit_ok = $onehot(w_an_low);

    always_comb begin
        w_idx = 2'd0;
        if (w_an_low[1]) w_idx = 2'd1;
        if (w_an_low[2]) w_idx = 2'd2;
        if (w_an_low[3]) w_idx = 2'd3;
    end

    assign w_tuple = {w_idx, w_seg};
    assign w_same  = (w_tuple == r_last);

    seven_seg_decode u_decode (
        .i_seg    (w_seg),
        .o_hit    (w_hit),
        .o_nibble (w_nibble)
    );

    // The capture lands on the same edge that sees the last of STABLE_CYCLES equal samples.
    assign w_capture  = (r_state == SETTLE) && w_digit_ok && w_same && (r_cnt == CNT_LAST);
    assign w_hit_cap  = w_capture && w_hit;
    assign w_miss_cap = w_capture && !w_hit;
    assign w_mask_set = r_mask | (4'b0001 << w_idx);
    assign w_frame    = w_hit_cap && (w_mask_set == 4'hF);
    assign w_to_sat   = (r_to == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_last  <= 9'd0;
        end else begin
            r_last <= w_tuple;
            case (r_state)
                IDLE: begin
                    if (w_digit_ok) begin
                        r_state <= SETTLE;
                        r_cnt   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!w_digit_ok) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (!w_same) begin
                        r_cnt <= 8'd1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (!w_digit_ok) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (!w_same) begin
                        r_state <= SETTLE;
                        r_cnt   <= 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_val[i] <= 4'h0;
            r_valid   <= 4'h0;
            r_mask    <= 4'h0;
            r_blank   <= 1'b0;
            r_seg_err <= 1'b0;
            r_frame   <= 1'b0;
            r_to      <= '0;
        end else begin
            r_seg_err <= w_miss_cap;
            r_frame   <= w_frame;
            if (w_capture) begin
                r_to <= '0;
            end else if (!w_to_sat) begin
                r_to <= r_to + TO_W'(1);
            end
            // A capture on the saturation edge takes priority over blanking.
            if (w_hit_cap) begin
                r_val[w_idx]   <= w_nibble;
                r_valid[w_idx] <= 1'b1;
                r_blank        <= 1'b0;
                r_mask         <= w_frame ? 4'h0 : w_mask_set;
            end else if (w_miss_cap) begin
                r_valid[w_idx] <= 1'b0;
            end else if (w_to_sat) begin
                r_valid <= 4'h0;
                r_mask  <= 4'h0;
                r_blank <= 1'b1;
            end
        end
    end

`ifdef SEVSEG_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (err_clr) begin
            r_err_cnt <= 8'd0;
        end else if (w_miss_cap && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign val0        = r_val[0];
    assign val1        = r_val[1];
    assign val2        = r_val[2];
    assign val3        = r_val[3];
    assign valid       = r_valid;
    assign seg_err     = r_seg_err;
    assign frame_done  = r_frame;
    assign blank       = r_blank;
    assign o_dbg_state = r_state;
    assign o_dbg_dp    = w_pins[0];

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random bus traffic,
// checked every cycle against a run-length model of the snooped display.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int FT     = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] an_pins = 4'hF;
    logic [6:0] seg_pins = 7'h7F;
    logic       dp_pin = 1'b1;

    logic [3:0] val3, val2, val1, val0, valid;
    logic       seg_err, frame_done, blank;
    logic [1:0] dbg_state;
    logic       dbg_dp;
`ifdef SEVSEG_ERR_CNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;
    logic [7:0] exp_err_cnt;
`endif

    always #5 clk = ~clk;

    seven_seg_capture #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .FRAME_TIMEOUT (FT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an3         (an_pins[3]),
        .an2         (an_pins[2]),
        .an1         (an_pins[1]),
        .an0         (an_pins[0]),
        .ca          (seg_pins[6]),
        .cb          (seg_pins[5]),
        .cc          (seg_pins[4]),
        .cd          (seg_pins[3]),
        .ce          (seg_pins[2]),
        .cf          (seg_pins[1]),
        .cg          (seg_pins[0]),
        .dp          (dp_pin),
        .val3        (val3),
        .val2        (val2),
        .val1        (val1),
        .val0        (val0),
        .valid       (valid),
        .seg_err     (seg_err),
        .frame_done  (frame_done),
        .blank       (blank),
`ifdef SEVSEG_ERR_CNT_EN
        .err_clr     (err_clr),
        .err_cnt     (err_cnt),
`endif
        .o_dbg_state (dbg_state),
        .o_dbg_dp    (dbg_dp)
    );

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int checks = 0;
    int errors = 0;
    int seg_err_pulses = 0;
    int frame_pulses = 0;
    logic chk_en = 1'b0;

    // Model: what the display shows, derived from the sampled pin history.
    logic [10:0] pin_q [$];
    logic [10:0] prev_smp;
    logic        prev_ok;
    int          run;
    int          edge_n;
    int          last_cap;
    logic [3:0]  exp_val [4];
    logic [3:0]  exp_valid, exp_mask;
    logic        exp_blank, exp_seg_err, exp_frame;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode_ref(input logic [6:0] s, output logic hit, output logic [3:0] nib);
        hit = 1'b0;
        nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == s) begin
                hit = 1'b1;
                nib = 4'(i);
            end
        end
        if (s == 7'b0001101) begin hit = 1'b1; nib = 4'h7; end
        if (s == 7'b0001100) begin hit = 1'b1; nib = 4'h9; end
    endfunction

    task automatic model_reset();
        pin_q = {};
        for (int i = 0; i < SYNC; i++) pin_q.push_back(11'h7FF);
        prev_smp = 11'h7FF;
        prev_ok = 1'b0;
        run = 0;
        edge_n = 0;
        last_cap = 0;
        for (int i = 0; i < 4; i++) exp_val[i] = 4'h0;
        exp_valid = 4'h0;
        exp_mask = 4'h0;
        exp_blank = 1'b0;
        exp_seg_err = 1'b0;
        exp_frame = 1'b0;
`ifdef SEVSEG_ERR_CNT_EN
        exp_err_cnt = 8'd0;
`endif
    endtask

    task automatic model_step();
        logic [10:0] smp;
        logic        ok, hit;
        logic [3:0]  nib;
        logic [1:0]  idx;
        int          lows;
        smp = pin_q.pop_front();
        pin_q.push_back({an_pins, seg_pins});
        lows = 0;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!smp[7+i]) begin
                lows++;
                idx = 2'(i);
            end
        end
        ok = (lows == 1);
        if (ok && prev_ok && (smp == prev_smp)) run++;
        else run = ok ? 1 : 0;
        prev_ok = ok;
        prev_smp = smp;
        edge_n++;
        exp_seg_err = 1'b0;
        exp_frame = 1'b0;
        if (ok && run == STABLE) begin
            last_cap = edge_n;
            decode_ref(smp[6:0], hit, nib);
            if (hit) begin
                exp_val[idx] = nib;
                exp_valid[idx] = 1'b1;
                exp_blank = 1'b0;
                exp_mask[idx] = 1'b1;
                if (exp_mask == 4'hF) begin
                    exp_frame = 1'b1;
                    exp_mask = 4'h0;
                end
            end else begin
                exp_seg_err = 1'b1;
                exp_valid[idx] = 1'b0;
            end
        end else if (edge_n - last_cap >= FT) begin
            exp_valid = 4'h0;
            exp_mask = 4'h0;
            exp_blank = 1'b1;
        end
`ifdef SEVSEG_ERR_CNT_EN
        if (err_clr) exp_err_cnt = 8'd0;
        else if (exp_seg_err && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("val0", 8'(val0), 8'(exp_val[0]));
            check("val1", 8'(val1), 8'(exp_val[1]));
            check("val2", 8'(val2), 8'(exp_val[2]));
            check("val3", 8'(val3), 8'(exp_val[3]));
            check("valid", 8'(valid), 8'(exp_valid));
            check("seg_err", 8'(seg_err), 8'(exp_seg_err));
            check("frame_done", 8'(frame_done), 8'(exp_frame));
            check("blank", 8'(blank), 8'(exp_blank));
`ifdef SEVSEG_ERR_CNT_EN
            check("err_cnt", err_cnt, exp_err_cnt);
`endif
        end
        if (seg_err === 1'b1) seg_err_pulses++;
        if (frame_done === 1'b1) frame_pulses++;
    end

    task automatic check_zero(input string tag);
        check({tag, "_vals"}, 8'({val3, val2}), 8'h00);
        check({tag, "_vals_lo"}, 8'({val1, val0}), 8'h00);
        check({tag, "_valid"}, 8'(valid), 8'h00);
        check({tag, "_flags"}, 8'({seg_err, frame_done, blank}), 8'h00);
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int cyc);
        an_pins = an;
        seg_pins = seg;
        dp_pin = 1'($urandom_range(0, 1));
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        int e0, f0, r;
        logic [3:0] an;
        logic [6:0] seg;

        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Digit 0 showing 3: capture lands on edge 6 after the pin change.
        @(negedge clk);
        an_pins = 4'b1110;
        seg_pins = 7'b0000110;
        repeat (5) @(posedge clk);
        #1 check("t2_valid_edge5", 8'(valid), 8'h00);
        @(posedge clk);
        #1 check("t2_val0_edge6", 8'(val0), 8'h03);
        check("t2_valid_edge6", 8'(valid), 8'h01);
        repeat (4) @(posedge clk);
        #1 check("t2_valid_held", 8'(valid), 8'h01);
        @(negedge clk);

        // Short stable interval on digit 2: no capture.
        hold(4'b1011, 7'b0010010, 3);
        hold(4'b1011, 7'b1001111, 2);
        hold(4'hF, 7'h7F, 6);
        check("t3_valid", 8'(valid), 8'h01);
        check("t3_val2", 8'(val2), 8'h00);

        // Undecodable pattern on digit 2: one error pulse.
        e0 = seg_err_pulses;
        hold(4'b1011, 7'b1111110, 8);
        hold(4'hF, 7'h7F, 4);
        check("t4_err_pulses", 8'(seg_err_pulses - e0), 8'd1);
        check("t4_valid", 8'(valid), 8'h01);
        check("t4_val2", 8'(val2), 8'h00);

        // Reset in the middle of a settle interval.
        hold(4'b1110, 7'b1001111, 4);
        #2 rst_n = 1'b0;
        #1 check_zero("t1_midreset");
        an_pins = 4'hF;
        seg_pins = 7'h7F;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_zero("t1_after");

        // Full scan of four digits: one frame_done.
        f0 = frame_pulses;
        hold(4'b1110, seg_tab[1], 20);
        hold(4'b1101, seg_tab[2], 20);
        hold(4'b1011, seg_tab[3], 20);
        hold(4'b0111, seg_tab[4], 20);
        check("t5_frame_pulses", 8'(frame_pulses - f0), 8'd1);
        check("t5_vals", 8'({val3, val2}), 8'h43);
        check("t5_vals_lo", 8'({val1, val0}), 8'h21);
        check("t5_valid", 8'(valid), 8'h0F);

        // Two anodes low, then a dark bus until the timeout expires.
        hold(4'b0101, seg_tab[8], 20);
        check("t6_no_capture", 8'(valid), 8'h0F);
        check("t6_not_blank", 8'(blank), 8'h00);
        hold(4'hF, 7'h7F, FT + 4);
        check("t6_valid", 8'(valid), 8'h00);
        check("t6_blank", 8'(blank), 8'h01);

        // Random bus traffic.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) an = 4'hF;
            else if (r == 8) an = ~((4'b0001 << $urandom_range(0, 1)) | (4'b0100 << $urandom_range(0, 1)));
            else an = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            if (r < 12) seg = seg_tab[$urandom_range(0, 15)];
            else if (r < 14) seg = ($urandom_range(0, 1) != 0) ? 7'b0001101 : 7'b0001100;
            else seg = 7'($urandom_range(0, 127));
            hold(an, seg, $urandom_range(1, 9));
            if ($urandom_range(0, 59) == 0) hold(4'hF, 7'h7F, FT + $urandom_range(0, 10));
`ifdef SEVSEG_ERR_CNT_EN
            if ($urandom_range(0, 15) == 0) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
`endif
            if (k == 150) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        hold(4'hF, 7'h7F, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
